fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
- REQ-001: Parameter NUM_REQ, default 4: number of write requesters, range 2..8.
- REQ-002: Parameter DW, default 16: data width, equal to the shared FIFO DATA_WIDTH.
- REQ-003: Parameter MAX_BURST, default 16: maximum words per grant, range 1..256.
- REQ-004: One clock; reset is asynchronous and active-low.
- REQ-005: Port clk_i, input, 1 bit: sole clock; every register is clocked on its rising edge.
- REQ-006: Port rst_n_i, input, 1 bit: asynchronous active-low reset.
- REQ-007: Port req_valid_i, input, NUM_REQ bits: per-requester word valid.
- REQ-008: Port req_data_i, input, NUM_REQ*DW bits: requester k's word occupies bits [k*DW +: DW].
- REQ-009: Port req_last_i, input, NUM_REQ bits: marks the current word as the last of its packet.
- REQ-010: Port req_ready_o, output, NUM_REQ bits: per-requester word accepted.
- REQ-011: Port fifo_wr_en_o, output, 1 bit: FIFO write enable.
- REQ-012: Port fifo_wr_data_o, output, DW bits: FIFO write data.
- REQ-013: Port fifo_full_i, input, 1 bit: FIFO full flag, synchronous to clk_i.
- REQ-014: Port grant_o, output, NUM_REQ bits: one-hot current owner; all zero when no owner.
- REQ-015: Port busy_o, output, 1 bit: high while the state is GRANT.

Function
- REQ-016: State machine SHALL have the states IDLE and GRANT.
- REQ-017: In IDLE with any bit of req_valid_i high, the block SHALL enter GRANT at the next edge.
  - The owner is chosen round-robin: first valid index after last_owner, wrapping from NUM_REQ-1 to 0.
- REQ-018: last_owner SHALL be loaded with the granted index on every IDLE->GRANT transition.
- REQ-019: In GRANT, req_ready_o[owner] SHALL equal !fifo_full_i; all other ready bits SHALL be 0.
- REQ-020: In IDLE, all req_ready_o bits SHALL be 0, as SHALL fifo_wr_en_o.
- REQ-021: A transfer is req_valid_i[owner] && req_ready_o[owner] in GRANT.
  - fifo_wr_en_o SHALL equal transfer, combinationally, with zero latency.
- REQ-022: fifo_wr_data_o SHALL equal the owner's data slice in GRANT and 0 in IDLE.
- REQ-023: fifo_wr_en_o SHALL never be high while fifo_full_i is high.
- REQ-024: A burst counter of width clog2(MAX_BURST+1) SHALL clear on IDLE->GRANT and increment on each transfer.
- REQ-025: The block SHALL go GRANT->IDLE at the edge of a transfer with req_last_i[owner]=1, or when the counter reaches MAX_BURST.
- REQ-026: Whenever it leaves GRANT, the block SHALL spend exactly one cycle in IDLE (an arbitration bubble) before any new grant.
- REQ-027: If the owner deasserts valid mid-packet, the grant SHALL be held (packet lock) with no timeout.
- REQ-028: Non-owner valid changes SHALL NOT affect the current grant.
- REQ-029: fifo_full_i high SHALL stall the transfer without advancing the counter or releasing the grant.
- REQ-030: A full word, or a last word, stalled by fifo_full_i SHALL be transferred once full clears.
- REQ-031: grant_o SHALL be one-hot of the owner in GRANT and zero in IDLE; busy_o = (state==GRANT).

Reset
- REQ-032: rst_n_i low SHALL immediately, without a clock, set the state to IDLE, last_owner to NUM_REQ-1, and the counter to 0.
- REQ-033: While rst_n_i is low, req_ready_o, fifo_wr_en_o, fifo_wr_data_o, grant_o and busy_o SHALL all be 0.
- REQ-034: Reset asserted mid-burst SHALL drop the grant with no further FIFO write.
- REQ-035: After reset, the first arbitration SHALL start its search at index 0.
- REQ-036: Reset deassertion SHALL be treated as synchronous to clk_i by the integrator.

Verification
- REQ-037: After reset, req_valid_i=4'b1111, every word last -> grants in order 0,1,2,3,0.
  - Each grant moves one word, followed by one IDLE cycle.
- REQ-038: Requester 2 sends 40 words with no last, MAX_BURST=16 -> bursts of 16,16,8 words.
  - Each burst is separated by one IDLE cycle; FIFO contents arrive in order.
- REQ-039: fifo_full_i held high 5 cycles mid-burst -> fifo_wr_en_o=0 and ready=0 for those cycles.
  - Grant is held, the counter is frozen, and no word is lost or duplicated.
- REQ-040: Owner 1 drops valid for 3 cycles mid-packet while requester 3 is valid -> grant_o stays 4'b0010 until 1's last word.
- REQ-041: rst_n_i pulsed low between clock edges mid-burst -> all outputs 0 immediately.
  - The next grant goes to the lowest valid index.
- REQ-042: Random 10000-word traffic from 4 requesters against a FIFO with random full.
  - Per-requester order is preserved, packets are never interleaved, and no FIFO write occurs while full.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter for a shared FIFO. It grants one requester per packet,
// with a burst cap per grant and a one-cycle bubble before each new arbitration.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DW        = 16,
  parameter int MAX_BURST = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [NUM_REQ*DW-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]    req_last_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic                  fifo_wr_en_o,
  output logic [DW-1:0]         fifo_wr_data_o,
  input  logic                  fifo_full_i,
  output logic [NUM_REQ-1:0]    grant_o,
  output logic                  busy_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_LAST  = CW'(MAX_BURST - 1);
  localparam logic [IW-1:0] RESET_OWNER = IW'(NUM_REQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t              state_r, state_nxt_s;
  // last_owner_r doubles as the current owner while in GRANT
  logic [IW-1:0]       last_owner_r;
  logic [IW-1:0]       pick_s;
  logic [IW-1:0]       idx_s;
  logic                pick_valid_s;
  logic [CW-1:0]       cnt_r;
  logic                transfer_s;
  logic                release_s;
  logic [NUM_REQ-1:0]  ready_s;
  logic [NUM_REQ-1:0]  grant_s;
  logic [DW-1:0]       wr_data_s;

  // Round-robin search: first valid index after the previous owner, wrapping.
  always_comb begin
    pick_s       = '0;
    pick_valid_s = 1'b0;
    idx_s        = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx_s = IW'((int'(last_owner_r) + i) % NUM_REQ);
      if (!pick_valid_s && req_valid_i[idx_s]) begin
        pick_valid_s = 1'b1;
        pick_s       = idx_s;
      end else begin
        pick_valid_s = pick_valid_s;
      end
    end
  end

  assign transfer_s = (state_r == GRANT) && req_valid_i[last_owner_r] && !fifo_full_i;
  assign release_s  = transfer_s && (req_last_i[last_owner_r] || (cnt_r == BURST_LAST));

  // Next-state and per-owner output decode.
  always_comb begin
    state_nxt_s = state_r;
    ready_s     = '0;
    grant_s     = '0;
    wr_data_s   = '0;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          state_nxt_s = GRANT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        ready_s[last_owner_r] = !fifo_full_i;
        grant_s[last_owner_r] = 1'b1;
        wr_data_s             = req_data_i[int'(last_owner_r)*DW +: DW];
        if (release_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GRANT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, owner and burst counter registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r      <= IDLE;
      last_owner_r <= RESET_OWNER;
      cnt_r        <= '0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == IDLE) && pick_valid_s) begin
        last_owner_r <= pick_s;
        cnt_r        <= '0;
      end else if (transfer_s) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign req_ready_o    = ready_s;
  assign grant_o        = grant_s;
  assign fifo_wr_data_o = wr_data_s;
  assign fifo_wr_en_o   = transfer_s;
  assign busy_o         = (state_r == GRANT);

endmodule
